// File: rtl/enemy_collision_resolver.sv
// Once-per-frame Mario vs. goomba contact resolver: scans each slot sequentially,
// classifies stomp vs. side contact, and issues kill/bounce/hit pulses.
module enemy_collision_resolver #(
  parameter int unsigned             N_SLOTS       = 4,
  parameter logic [2*N_SLOTS-1:0]    SLOT_ROOMS    = 8'b11100101,
  parameter int unsigned             GOOMBA_SIZE   = 16,
  parameter int unsigned             MARIO_SIZE_X  = 16,
  parameter int unsigned             STOMP_MARGIN  = 4,
  parameter int unsigned             INVULN_FRAMES = 60
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [1:0]            roomNum,
  input  logic [9:0]            mario_x,
  input  logic [9:0]            mario_y,
  input  logic [9:0]            mario_size_y,
  input  logic                  mario_falling,
  input  logic [1:0]            is_alive_mario,
  input  logic [10*N_SLOTS-1:0] goomba_x,
  input  logic [10*N_SLOTS-1:0] goomba_y,
  input  logic [N_SLOTS-1:0]    goomba_alive,
  output logic [N_SLOTS-1:0]    goomba_kill,
  output logic                  mario_bounce,
  output logic                  mario_hit,
  output logic                  invulnerable,
  output logic                  busy
);

  localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [10:0] G_SIZE  = 11'(GOOMBA_SIZE);
  localparam logic [10:0] M_SIZE  = 11'(MARIO_SIZE_X);
  localparam logic [10:0] S_MARG  = 11'(STOMP_MARGIN);

  typedef enum logic [1:0] {IDLE, SNAP, SCAN, RESOLVE} state_t;

  state_t             state;
  logic               fc_q, fc_q2, pending;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   inv_cnt;
  logic [N_SLOTS-1:0] stomp_mask;
  logic               side_flag;

  // Latched Mario state, held zero-extended to 11 bits so sums never wrap.
  logic [10:0] mx, my, msy;
  logic        falling_l, alive_l;
  logic [1:0]  room_l;

  logic        tick;
  logic [10:0] gx, gy;
  logic        eligible, overlap, stomp;

  assign tick         = fc_q & ~fc_q2;
  assign busy         = (state != IDLE);
  assign invulnerable = (inv_cnt != '0);

  // Slot coordinates are read live during the scan.
  always_comb begin
    gx       = {1'b0, goomba_x[int'(idx)*10 +: 10]};
    gy       = {1'b0, goomba_y[int'(idx)*10 +: 10]};
    eligible = goomba_alive[idx] && (SLOT_ROOMS[int'(idx)*2 +: 2] == room_l) && alive_l;
    overlap  = (mx < gx + G_SIZE) && (gx < mx + M_SIZE) &&
               (my < gy + G_SIZE) && (gy < my + msy);
    stomp    = falling_l && ((my + msy) <= (gy + S_MARG));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      fc_q         <= 1'b0;
      fc_q2        <= 1'b0;
      pending      <= 1'b0;
      idx          <= '0;
      inv_cnt      <= '0;
      stomp_mask   <= '0;
      side_flag    <= 1'b0;
      mx           <= '0;
      my           <= '0;
      msy          <= '0;
      falling_l    <= 1'b0;
      alive_l      <= 1'b0;
      room_l       <= '0;
      goomba_kill  <= '0;
      mario_bounce <= 1'b0;
      mario_hit    <= 1'b0;
    end else begin
      fc_q         <= frame_clk;
      fc_q2        <= fc_q;
      goomba_kill  <= '0;
      mario_bounce <= 1'b0;
      mario_hit    <= 1'b0;

      if (tick && inv_cnt != '0) inv_cnt <= inv_cnt - CNT_W'(1);
      if (tick && state != IDLE) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (tick || pending) begin
            pending <= 1'b0;
            state   <= SNAP;
          end
        end
        SNAP: begin
          mx         <= {1'b0, mario_x};
          my         <= {1'b0, mario_y};
          msy        <= {1'b0, mario_size_y};
          falling_l  <= mario_falling;
          alive_l    <= (is_alive_mario != 2'b00);
          room_l     <= roomNum;
          stomp_mask <= '0;
          side_flag  <= 1'b0;
          idx        <= '0;
          state      <= SCAN;
        end
        SCAN: begin
          if (eligible && overlap) begin
            if (stomp) stomp_mask[idx] <= 1'b1;
            else       side_flag       <= 1'b1;
          end
          if (idx == IDX_W'(N_SLOTS - 1)) state <= RESOLVE;
          else                            idx   <= idx + IDX_W'(1);
        end
        RESOLVE: begin
          // A stomp anywhere in the frame wins over any side contact.
          if (stomp_mask != '0) begin
            goomba_kill  <= stomp_mask;
            mario_bounce <= 1'b1;
          end else if (side_flag && inv_cnt == '0) begin
            mario_hit <= 1'b1;
            inv_cnt   <= CNT_W'(INVULN_FRAMES);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_collision_resolver.sv
// Directed bench for enemy_collision_resolver: stomp, side hit, invulnerability,
// room gating, no-wrap arithmetic, pending tick handling and mid-scan reset.
module tb_enemy_collision_resolver;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [1:0]  roomNum;
  logic [9:0]  mario_x, mario_y, mario_size_y;
  logic        mario_falling;
  logic [1:0]  is_alive_mario;
  logic [39:0] goomba_x, goomba_y;
  logic [3:0]  goomba_alive;
  logic [3:0]  goomba_kill;
  logic        mario_bounce, mario_hit, invulnerable, busy;

  int passed = 0;
  int total  = 0;

  logic [3:0] kill_acc;
  int         bounce_cnt, hit_cnt, first_edge, last_edge;

  enemy_collision_resolver #(
    .N_SLOTS(4), .SLOT_ROOMS(8'b11100101), .GOOMBA_SIZE(16),
    .MARIO_SIZE_X(16), .STOMP_MARGIN(4), .INVULN_FRAMES(60)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .roomNum(roomNum),
    .mario_x(mario_x), .mario_y(mario_y), .mario_size_y(mario_size_y),
    .mario_falling(mario_falling), .is_alive_mario(is_alive_mario),
    .goomba_x(goomba_x), .goomba_y(goomba_y), .goomba_alive(goomba_alive),
    .goomba_kill(goomba_kill), .mario_bounce(mario_bounce), .mario_hit(mario_hit),
    .invulnerable(invulnerable), .busy(busy)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_slot(input int i, input logic [9:0] x, input logic [9:0] y, input logic a);
    goomba_x[i*10 +: 10] = x;
    goomba_y[i*10 +: 10] = y;
    goomba_alive[i]      = a;
  endtask

  task automatic sample(input int k);
    kill_acc   |= goomba_kill;
    bounce_cnt += int'(mario_bounce);
    hit_cnt    += int'(mario_hit);
    if ((goomba_kill != 0 || mario_bounce || mario_hit)) begin
      if (first_edge < 0) first_edge = k;
      last_edge = k;
    end
  endtask

  // One frame strobe; observe 12 edges after the edge that registers it.
  // If mid_en, roomNum is switched to mid_room once the snapshot has been taken.
  task automatic run_frame(input logic mid_en, input logic [1:0] mid_room);
    kill_acc = '0; bounce_cnt = 0; hit_cnt = 0; first_edge = -1; last_edge = -1;
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge Clk); #1;
      sample(k);
      if (mid_en && k == 3) roomNum = mid_room;
    end
  endtask

  task automatic stomp_geometry();
    roomNum = 2'd1; mario_x = 10'd100; mario_y = 10'd184; mario_size_y = 10'd16;
    mario_falling = 1'b1; is_alive_mario = 2'b01;
    goomba_alive = '0; goomba_x = '0; goomba_y = '0;
    set_slot(0, 10'd100, 10'd198, 1'b1);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0;
    stomp_geometry();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_kill", 32'(goomba_kill), 0);
    chk("rst_bounce", 32'(mario_bounce), 0);
    chk("rst_hit", 32'(mario_hit), 0);
    chk("rst_inv", 32'(invulnerable), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge Clk); Reset = 1'b0;
    repeat (2) @(posedge Clk);

    // Basic stomp on slot 0
    run_frame(1'b0, 2'd0);
    chk("stomp_kill", 32'(kill_acc), 4'b0001);
    chk("stomp_bounce_cnt", 32'(bounce_cnt), 1);
    chk("stomp_hit_cnt", 32'(hit_cnt), 0);
    chk("stomp_latency", 32'(first_edge), 7);
    chk("stomp_busy_after", 32'(busy), 0);

    // Side hit, then invulnerability window
    mario_falling = 1'b0;
    run_frame(1'b0, 2'd0);
    chk("side_hit_cnt", 32'(hit_cnt), 1);
    chk("side_kill", 32'(kill_acc), 0);
    chk("side_bounce", 32'(bounce_cnt), 0);
    chk("side_latency", 32'(first_edge), 7);
    chk("side_inv", 32'(invulnerable), 1);
    for (int t = 1; t <= 60; t++) begin
      run_frame(1'b0, 2'd0);
      if (t == 30) begin
        chk("inv_tick30_hit", 32'(hit_cnt), 0);
        chk("inv_tick30_inv", 32'(invulnerable), 1);
        goomba_alive = '0;
      end
      if (t == 59) chk("inv_tick59", 32'(invulnerable), 1);
      if (t == 60) chk("inv_tick60", 32'(invulnerable), 0);
    end

    // Two stomps in one scan
    stomp_geometry();
    set_slot(1, 10'd100, 10'd198, 1'b1);
    run_frame(1'b0, 2'd0);
    chk("dbl_kill", 32'(kill_acc), 4'b0011);
    chk("dbl_bounce_cnt", 32'(bounce_cnt), 1);
    chk("dbl_hit", 32'(hit_cnt), 0);

    // Stomp on slot 0 with a side contact on slot 1: stomp wins
    set_slot(1, 10'd100, 10'd186, 1'b1);
    run_frame(1'b0, 2'd0);
    chk("prio_kill", 32'(kill_acc), 4'b0001);
    chk("prio_bounce_cnt", 32'(bounce_cnt), 1);
    chk("prio_hit", 32'(hit_cnt), 0);
    chk("prio_inv", 32'(invulnerable), 0);

    // Room gating: current room 2, only slot 0 (room 1) overlaps
    stomp_geometry();
    roomNum = 2'd2;
    mario_falling = 1'b0;
    run_frame(1'b0, 2'd0);
    chk("room_kill", 32'(kill_acc), 0);
    chk("room_bounce", 32'(bounce_cnt), 0);
    chk("room_hit", 32'(hit_cnt), 0);

    // Room change after the snapshot is ignored
    stomp_geometry();
    run_frame(1'b1, 2'd2);
    chk("midroom_kill", 32'(kill_acc), 4'b0001);
    chk("midroom_bounce", 32'(bounce_cnt), 1);

    // Right-edge geometry: 1015+16 must not wrap
    stomp_geometry();
    goomba_alive = '0;
    roomNum = 2'd3; mario_x = 10'd1010;
    set_slot(3, 10'd1015, 10'd198, 1'b1);
    run_frame(1'b0, 2'd0);
    chk("wrap_kill", 32'(kill_acc), 4'b1000);
    chk("wrap_bounce", 32'(bounce_cnt), 1);

    // Dead Mario
    stomp_geometry();
    is_alive_mario = 2'b00;
    run_frame(1'b0, 2'd0);
    chk("dead_kill", 32'(kill_acc), 0);
    chk("dead_bounce", 32'(bounce_cnt), 0);
    chk("dead_hit", 32'(hit_cnt), 0);

    // Three ticks: second queues one extra scan, third is dropped
    stomp_geometry();
    kill_acc = '0; bounce_cnt = 0; hit_cnt = 0; first_edge = -1; last_edge = -1;
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge Clk); #1;
      sample(k);
      frame_clk = (k == 2 || k == 4);
    end
    chk("pend_bounce_cnt", 32'(bounce_cnt), 2);
    chk("pend_first", 32'(first_edge), 7);
    chk("pend_second", 32'(last_edge), 14);
    chk("pend_busy_end", 32'(busy), 0);

    // Reset during SCAN
    @(negedge Clk); frame_clk = 1'b1;
    @(posedge Clk); #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 1);
    Reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_kill", 32'(goomba_kill), 0);
    chk("midrst_bounce", 32'(mario_bounce), 0);
    chk("midrst_hit", 32'(mario_hit), 0);
    repeat (10) begin
      @(posedge Clk); #1;
      if (goomba_kill != 0 || mario_bounce) chk("midrst_no_pulse", 1, 0);
    end
    @(negedge Clk); Reset = 1'b0;
    repeat (2) @(posedge Clk);
    run_frame(1'b0, 2'd0);
    chk("postrst_kill", 32'(kill_acc), 4'b0001);
    chk("postrst_latency", 32'(first_edge), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

endmodule
